// File: rtl/reg_bank_8.sv
// Eight-entry register bank feeding an external 8:1 mux, with registered
// mux selects, a one-cycle read-valid strobe and per-register written flags.
module reg_bank_8 #(
   parameter int WIDTH   = 16,
   parameter int ZERO_R0 = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [2:0]       waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd_req,
   input  logic [2:0]       raddr,
   input  logic             clr_written,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7,
   output logic             s0,
   output logic             s1,
   output logic             s2,
   output logic             rd_valid,
   output logic [7:0]       written
);

   logic [WIDTH-1:0] regs [8];
   logic [2:0]       sel;
   logic             wr_ok;

   // Writes to register 0 are dropped entirely when it is hardwired to zero.
   assign wr_ok = we && !((ZERO_R0 != 0) && (waddr == 3'd0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) regs[i] <= '0;
         written <= 8'h00;
      end else begin
         if (clr_written) written <= 8'h00;
         if (wr_ok) begin
            regs[waddr]    <= wdata;
            written[waddr] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel      <= 3'd0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_req;
         if (rd_req) sel <= raddr;
      end
   end

   assign q0 = regs[0];
   assign q1 = regs[1];
   assign q2 = regs[2];
   assign q3 = regs[3];
   assign q4 = regs[4];
   assign q5 = regs[5];
   assign q6 = regs[6];
   assign q7 = regs[7];
   assign s0 = sel[0];
   assign s1 = sel[1];
   assign s2 = sel[2];

endmodule

// File: tb/tb_reg_bank_8.sv
// Randomized self-checking bench for reg_bank_8; runs one instance with
// register 0 hardwired to zero and one with it writable, both on the same stimulus.
module tb_reg_bank_8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        we = 1'b0;
   logic [2:0]  waddr = 3'd0;
   logic [15:0] wdata = 16'd0;
   logic        rd_req = 1'b0;
   logic [2:0]  raddr = 3'd0;
   logic        clr_written = 1'b0;

   wire  [15:0] qz [8];
   wire  [15:0] qn [8];
   wire         zs0, zs1, zs2, zvld, ns0, ns1, ns2, nvld;
   wire  [7:0]  zwr, nwr;

   int total = 0;
   int bad = 0;

   // reference state: plain arrays updated by the spec's rules
   logic [15:0] mem_z [8];
   logic [15:0] mem_n [8];
   logic [7:0]  wr_z, wr_n;
   logic [2:0]  msel;
   logic        mvld;

   always #5 clk = ~clk;

   reg_bank_8 #(.WIDTH(16), .ZERO_R0(1)) dut_z (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rd_req(rd_req), .raddr(raddr), .clr_written(clr_written),
      .q0(qz[0]), .q1(qz[1]), .q2(qz[2]), .q3(qz[3]),
      .q4(qz[4]), .q5(qz[5]), .q6(qz[6]), .q7(qz[7]),
      .s0(zs0), .s1(zs1), .s2(zs2), .rd_valid(zvld), .written(zwr)
   );

   reg_bank_8 #(.WIDTH(16), .ZERO_R0(0)) dut_n (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .rd_req(rd_req), .raddr(raddr), .clr_written(clr_written),
      .q0(qn[0]), .q1(qn[1]), .q2(qn[2]), .q3(qn[3]),
      .q4(qn[4]), .q5(qn[5]), .q6(qn[6]), .q7(qn[7]),
      .s0(ns0), .s1(ns1), .s2(ns2), .rd_valid(nvld), .written(nwr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mem_z[i] = 16'd0;
         mem_n[i] = 16'd0;
      end
      wr_z = 8'h00;
      wr_n = 8'h00;
      msel = 3'd0;
      mvld = 1'b0;
   endtask

   task automatic check_all();
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("qz%0d", i), {16'd0, qz[i]}, {16'd0, mem_z[i]});
         chk($sformatf("qn%0d", i), {16'd0, qn[i]}, {16'd0, mem_n[i]});
      end
      chk("sel_z", {29'd0, zs2, zs1, zs0}, {29'd0, msel});
      chk("sel_n", {29'd0, ns2, ns1, ns0}, {29'd0, msel});
      chk("vld_z", {31'd0, zvld}, {31'd0, mvld});
      chk("vld_n", {31'd0, nvld}, {31'd0, mvld});
      chk("wr_z", {24'd0, zwr}, {24'd0, wr_z});
      chk("wr_n", {24'd0, nwr}, {24'd0, wr_n});
      if (mvld) begin
         chk("mux_z", {16'd0, qz[{zs2, zs1, zs0}]}, {16'd0, mem_z[msel]});
         chk("mux_n", {16'd0, qn[{ns2, ns1, ns0}]}, {16'd0, mem_n[msel]});
      end
   endtask

   // Apply one cycle of stimulus, advance one edge, update the model, check.
   task automatic step(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic r, input logic [2:0] ra, input logic c);
      we = w; waddr = wa; wdata = wd; rd_req = r; raddr = ra; clr_written = c;
      @(posedge clk);
      if (c) begin
         wr_z = 8'h00;
         wr_n = 8'h00;
      end
      if (w) begin
         mem_n[wa] = wd;
         wr_n[wa]  = 1'b1;
         if (wa != 3'd0) begin
            mem_z[wa] = wd;
            wr_z[wa]  = 1'b1;
         end
      end
      mvld = r;
      if (r) msel = ra;
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      model_clear();
      #1;
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      idle();

      // write reg 5 then read it back through the selects
      step(1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 1'b0);
      chk("q5_after_write", {16'd0, qz[5]}, 32'h1234);
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd5, 1'b0);
      chk("sel_101", {29'd0, zs2, zs1, zs0}, 32'd5);
      chk("vld_rd5", {31'd0, zvld}, 32'd1);
      chk("written_20", {24'd0, zwr}, 32'h20);
      idle();
      chk("vld_drop", {31'd0, zvld}, 32'd0);

      // register 0 write: discarded when hardwired, kept otherwise
      step(1'b1, 3'd0, 16'hBEEF, 1'b0, 3'd0, 1'b0);
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd0, 1'b0);
      chk("r0_zero", {16'd0, qz[0]}, 32'h0);
      chk("r0_wr_zero", {31'd0, zwr[0]}, 32'd0);
      chk("r0_norm", {16'd0, qn[0]}, 32'hBEEF);
      chk("r0_wr_norm", {31'd0, nwr[0]}, 32'd1);

      // write-first: same-edge write and read of reg 3
      step(1'b1, 3'd3, 16'h00AA, 1'b1, 3'd3, 1'b0);
      chk("wf_mux", {16'd0, qz[{zs2, zs1, zs0}]}, 32'h00AA);
      chk("wf_sel", {29'd0, zs2, zs1, zs0}, 32'd3);

      // back-to-back reads
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd1, 1'b0);
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd2, 1'b0);
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd7, 1'b0);
      chk("b2b_vld", {31'd0, zvld}, 32'd1);
      idle();
      chk("b2b_hold", {29'd0, zs2, zs1, zs0}, 32'd7);

      // fill every register then clear flags with a same-edge write to 6
      for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'(16'h1100 + i), 1'b0, 3'd0, 1'b0);
      chk("all_written", {24'd0, nwr}, 32'hFF);
      step(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 1'b1);
      chk("clr_win_n", {24'd0, nwr}, 32'h40);
      chk("clr_win_z", {24'd0, zwr}, 32'h40);
      chk("clr_keeps_q1", {16'd0, qn[1]}, 32'h1101);

      // reset landing mid-cycle while a strobe is up
      step(1'b0, 3'd0, 16'd0, 1'b1, 3'd4, 1'b0);
      #2 rst = 1'b1;
      #1;
      model_clear();
      check_all();
      @(posedge clk);
      #1 rst = 1'b0;
      idle();
      chk("no_strobe_after_rst", {31'd0, zvld}, 32'd0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 15) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_8.md
Name: reg_bank_8

Overview:
- Eight-entry, WIDTH-bit register bank that sits directly upstream of the 8:1 WIDTH-bit mux.
- Outputs q0..q7 drive mux inputs a..h.
- s0/s1/s2 drive the mux selects.
- A registered read request produces a one-cycle rd_valid strobe. rd_valid marks the cycle in which the downstream mux output holds the requested register.

Parameters:
WIDTH, 16, data width of each register and of q0..q7/wdata
ZERO_R0, 1, when 1 register 0 is hardwired to zero and writes to it are discarded

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
we  input  1  write enable, sampled on clk rising edge
waddr  input  3  write address 0..7
wdata  input  WIDTH  write data
rd_req  input  1  read request, sampled on clk rising edge
raddr  input  3  read address 0..7, sampled with rd_req
clr_written  input  1  synchronous clear of all written flags
q0..q7  output  WIDTH each  current register contents; connect to mux a..h
s0  output  1  registered select bit 0 (raddr[0])
s1  output  1  registered select bit 1 (raddr[1])
s2  output  1  registered select bit 2 (raddr[2])
rd_valid  output  1  one-cycle strobe: mux output is valid for the last accepted raddr
written  output  8  per-register sticky flag: bit i set once register i accepts a write

Behaviour:
- Reset (asserted, asynchronous) forces, immediately and regardless of clk:
  - all eight registers to 0
  - s0 = s1 = s2 = 0
  - rd_valid = 0
  - written = 8'h00
- Reset held: no writes or reads accepted. Deassertion takes effect at the next rising edge.
- Reset mid-operation (e.g. between rd_req and rd_valid): the pending rd_valid is dropped and no strobe appears after reset.
- Write:
  - On a rising edge with we=1, register[waddr] <= wdata and written[waddr] <= 1.
  - The new value is visible on q[waddr] from that edge onward (latency 1).
- ZERO_R0=1:
  - A write to address 0 is discarded; q0 stays 0 and written[0] stays 0.
  - written[0] never sets.
- ZERO_R0=0: register 0 behaves as any other register.
- q0..q7 are direct register outputs with no combinational path from wdata.
- Read:
  - On a rising edge with rd_req=1, {s2,s1,s0} <= raddr and rd_valid <= 1.
  - On an edge with rd_req=0, rd_valid <= 0 and the selects hold their last value.
  - rd_valid is high for exactly the cycle after each accepted rd_req.
  - Back-to-back rd_req on consecutive edges gives rd_valid continuously high, with the selects stepping each cycle.
  - Latency from rd_req edge to valid mux output is 1 cycle (the downstream mux is combinational).
- Simultaneous write and read of the same address on one edge: register and selects update on the same edge. The mux output during the rd_valid cycle shows the NEW wdata (write-first).
- Simultaneous write and read of different addresses: independent, no interaction.
- clr_written:
  - On an edge with clr_written=1, written <= 0, except the bit for a write accepted on that same edge, which is set (write wins).
  - clr_written has no effect on register contents.
- No handshake back-pressure: every rd_req and we is accepted on the edge where it is sampled.
- No wrap or overflow conditions exist: addresses are a full 3-bit range.

Test Plan:
- Reset → all q=0, {s2,s1,s0}=0, rd_valid=0, written=0. Assert rst mid-cycle → outputs clear before the next edge.
- Write 0x1234 to reg 5, then rd_req raddr=5 the next cycle → q5=0x1234 after write edge; {s2,s1,s0}=3'b101 and rd_valid=1 for exactly one cycle; written=8'h20.
- ZERO_R0=1: write 0xBEEF to reg 0, then read 0 → q0=0, written[0]=0. ZERO_R0=0: same stimulus → q0=0xBEEF, written[0]=1.
- Same edge: we=1 waddr=3 wdata=0x00AA with rd_req=1 raddr=3 → in the rd_valid cycle q3=0x00AA and selects=3'b011.
- Back-to-back rd_req raddr=1,2,7 on three edges → rd_valid high for three consecutive cycles, selects 001, 010, 111, then rd_valid=0 with selects holding 111.
- written=8'hFF, then on one edge clr_written=1 with we=1 waddr=6 → written=8'h40; register contents unchanged.
